// File: rtl/bus_rr_arbiter_if.sv
// Shared-bus arbitration bundle: per-port requests/data/control in, granted bus out.
// The master modport is the agents' view; the slave modport is the arbiter's view.
interface bus_rr_arbiter_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8
);
  logic [7:0]              req;
  logic [8*BUS_WIDTH-1:0]  bus_in;
  logic [8*CTRL_WIDTH-1:0] ctrl_in;
  logic [7:0]              ack;
  logic [BUS_WIDTH-1:0]    bus_out;
  logic [CTRL_WIDTH-1:0]   ctrl_out;
  logic [2:0]              owner;
  logic                    busy;
  logic                    timeout;

  modport master (
    output req, bus_in, ctrl_in,
    input  ack, bus_out, ctrl_out, owner, busy, timeout
  );

  modport slave (
    input  req, bus_in, ctrl_in,
    output ack, bus_out, ctrl_out, owner, busy, timeout
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Eight-port round-robin arbiter with one-cycle turnaround and a shared data/control mux.
// Optional grant-tenure watchdog enabled by defining BUS_RR_ARBITER_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic              clk,
  input  logic              rst_L,
  bus_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANTED  = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0] r_ack;
  logic [7:0] w_ack_nxt;
  logic [2:0] r_owner;
  logic [2:0] w_owner_nxt;
  logic [2:0] r_last_grant;
  logic [2:0] w_last_grant_nxt;
  logic       r_busy;
  logic       r_timeout;
  logic       w_timeout_nxt;

  logic [2:0] w_winner;
  logic [2:0] w_idx;
  logic       w_any_req;
  logic       w_wd_hit;

  logic [BUS_WIDTH-1:0]  w_bus_out;
  logic [CTRL_WIDTH-1:0] w_ctrl_out;

  if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_timeout_range_check
    $error("bus_rr_arbiter: TIMEOUT must lie in 2..65535");
  end

  // Rotating priority search: first requester after the last grant, wrapping back to it.
  always_comb begin
    w_winner  = 3'd0;
    w_any_req = 1'b0;
    w_idx     = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      w_idx = r_last_grant + 3'(i);
      if (!w_any_req && bus.req[w_idx]) begin
        w_winner  = w_idx;
        w_any_req = 1'b1;
      end else begin
        w_any_req = w_any_req;
      end
    end
  end

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
  localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_wd_cnt;

  // Tenure counter: held at zero outside GRANTED so every tenure starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state != ST_GRANTED) begin
      r_wd_cnt <= 16'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign w_wd_hit = (r_state == ST_GRANTED) && (r_wd_cnt == LP_WD_LAST);
`else
  assign w_wd_hit = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_ack_nxt        = r_ack;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_timeout_nxt    = 1'b0;
    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (w_any_req) begin
          w_state_nxt      = ST_GRANTED;
          w_ack_nxt        = 8'd1 << w_winner;
          w_owner_nxt      = w_winner;
          w_last_grant_nxt = w_winner;
        end else begin
          w_state_nxt = ST_IDLE;
          w_ack_nxt   = 8'd0;
        end
      end
      ST_GRANTED: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = ST_RELEASE;
          w_ack_nxt   = 8'd0;
        end else if (w_wd_hit) begin
          w_state_nxt   = ST_RELEASE;
          w_ack_nxt     = 8'd0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_GRANTED;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ack_nxt   = 8'd0;
      end
    endcase
  end

  // State and registered outputs; reset wins in any state, no turnaround inserted.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_state      <= ST_IDLE;
      r_ack        <= 8'd0;
      r_owner      <= 3'd0;
      r_last_grant <= 3'd7;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ack        <= w_ack_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_busy       <= |w_ack_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  // Shared bus mux: only the owner's slice during a tenure, zero otherwise.
  always_comb begin
    if (r_state == ST_GRANTED) begin
      w_bus_out  = bus.bus_in[r_owner*BUS_WIDTH +: BUS_WIDTH];
      w_ctrl_out = bus.ctrl_in[r_owner*CTRL_WIDTH +: CTRL_WIDTH];
    end else begin
      w_bus_out  = {BUS_WIDTH{1'b0}};
      w_ctrl_out = {CTRL_WIDTH{1'b0}};
    end
  end

  assign bus.ack      = r_ack;
  assign bus.owner    = r_owner;
  assign bus.busy     = r_busy;
  assign bus.timeout  = r_timeout;
  assign bus.bus_out  = w_bus_out;
  assign bus.ctrl_out = w_ctrl_out;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: reset, single grant, priority, rotation,
// reset mid-grant and long tenure (watchdog when BUS_RR_ARBITER_TIMEOUT_EN is defined).
module tb_bus_rr_arbiter;

  logic clk;
  logic rst_L;
  int   n_pass;
  int   n_fail;
  int   n_total;

  bus_rr_arbiter_if #(.BUS_WIDTH(32), .CTRL_WIDTH(8)) bif ();

  bus_rr_arbiter #(.BUS_WIDTH(32), .CTRL_WIDTH(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] port_data(input int i);
    if (i == 2) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic logic [7:0] port_ctrl(input int i);
    return 8'hC0 + 8'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    rst_L   = 1'b0;
    bif.req = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bif.bus_in[i*32 +: 32] = port_data(i);
      bif.ctrl_in[i*8 +: 8]  = port_ctrl(i);
    end

    // Reset state
    step();
    step();
    chk("rst_ack", 32'(bif.ack), 32'h00);
    chk("rst_owner", 32'(bif.owner), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_timeout", 32'(bif.timeout), 32'd0);
    chk("rst_bus_out", bif.bus_out, 32'h0);
    chk("rst_ctrl_out", 32'(bif.ctrl_out), 32'h0);

    // Single request on port 2
    rst_L   = 1'b1;
    bif.req = 8'h04;
    step();
    chk("single_ack", 32'(bif.ack), 32'h04);
    chk("single_owner", 32'(bif.owner), 32'd2);
    chk("single_busy", 32'(bif.busy), 32'd1);
    chk("single_bus_out", bif.bus_out, 32'hDEADBEEF);
    chk("single_ctrl_out", 32'(bif.ctrl_out), 32'(port_ctrl(2)));
    bif.req = 8'h00;
    step();
    chk("single_rel_ack", 32'(bif.ack), 32'h00);
    chk("single_rel_busy", 32'(bif.busy), 32'd0);
    chk("single_rel_bus", bif.bus_out, 32'h0);
    chk("single_rel_owner", 32'(bif.owner), 32'd2);
    step();

    // Post-reset priority: port 0 before port 7
    rst_L = 1'b0;
    step();
    rst_L   = 1'b1;
    bif.req = 8'h81;
    step();
    chk("prio_ack0", 32'(bif.ack), 32'h01);
    chk("prio_owner0", 32'(bif.owner), 32'd0);
    bif.req = 8'h80;
    step();
    chk("prio_gap", 32'(bif.ack), 32'h00);
    step();
    chk("prio_ack7", 32'(bif.ack), 32'h80);
    chk("prio_bus7", bif.bus_out, port_data(7));
    bif.req = 8'h00;
    step();
    step();

    // Rotation with all ports requesting: 0..7,0 with one idle cycle between tenures
    bif.req = 8'hFF;
    for (int t = 0; t < 9; t++) begin
      step();
      chk($sformatf("rot%0d_ack", t), 32'(bif.ack), 32'h1 << (t % 8));
      chk($sformatf("rot%0d_bus", t), bif.bus_out, port_data(t % 8));
      step();
      chk($sformatf("rot%0d_hold1", t), 32'(bif.ack), 32'h1 << (t % 8));
      step();
      chk($sformatf("rot%0d_hold2", t), 32'(bif.ack), 32'h1 << (t % 8));
      bif.req[t % 8] = 1'b0;
      step();
      chk($sformatf("rot%0d_gap", t), 32'(bif.ack), 32'h00);
      chk($sformatf("rot%0d_gapbusy", t), 32'(bif.busy), 32'd0);
      if (t < 8) bif.req = 8'hFF;
      else       bif.req = 8'h00;
    end
    step();

    // Reset mid-grant on port 5
    bif.req = 8'h20;
    step();
    chk("mid_ack", 32'(bif.ack), 32'h20);
    step();
    rst_L = 1'b0;
    step();
    chk("mid_rst_ack", 32'(bif.ack), 32'h00);
    chk("mid_rst_owner", 32'(bif.owner), 32'd0);
    chk("mid_rst_bus", bif.bus_out, 32'h0);
    chk("mid_rst_busy", 32'(bif.busy), 32'd0);
    rst_L = 1'b1;
    step();
    chk("mid_regrant_ack", 32'(bif.ack), 32'h20);
    chk("mid_regrant_owner", 32'(bif.owner), 32'd5);
    chk("mid_regrant_bus", bif.bus_out, port_data(5));
    bif.req = 8'h00;
    step();
    step();

    // Port 1 holds its request for 40 cycles
    bif.req = 8'h02;
    for (int c = 1; c <= 40; c++) begin
      step();
`ifdef BUS_RR_ARBITER_TIMEOUT_EN
      chk($sformatf("hold%0d_ack", c), 32'(bif.ack), (((c - 1) % 17) < 16) ? 32'h02 : 32'h00);
      chk($sformatf("hold%0d_to", c), 32'(bif.timeout), (((c - 1) % 17) == 16) ? 32'd1 : 32'd0);
`else
      chk($sformatf("hold%0d_ack", c), 32'(bif.ack), 32'h02);
      chk($sformatf("hold%0d_to", c), 32'(bif.timeout), 32'd0);
`endif
    end
    bif.req = 8'h00;
    step();
    step();

    // Ports 1 and 2 from reset: port 1 first, port 2 takes over only on revocation
    rst_L = 1'b0;
    step();
    rst_L   = 1'b1;
    bif.req = 8'h06;
`ifdef BUS_RR_ARBITER_TIMEOUT_EN
    for (int c = 1; c <= 17; c++) begin
      step();
      chk($sformatf("two%0d_ack", c), 32'(bif.ack), (c < 17) ? 32'h02 : 32'h00);
      chk($sformatf("two%0d_to", c), 32'(bif.timeout), (c == 17) ? 32'd1 : 32'd0);
    end
    step();
    chk("two_next_ack", 32'(bif.ack), 32'h04);
    chk("two_next_owner", 32'(bif.owner), 32'd2);
`else
    for (int c = 1; c <= 20; c++) begin
      step();
      chk($sformatf("two%0d_ack", c), 32'(bif.ack), 32'h02);
      chk($sformatf("two%0d_to", c), 32'(bif.timeout), 32'd0);
    end
`endif
    bif.req = 8'h00;
    step();
    chk("end_ack", 32'(bif.ack), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter and data/control multiplexer for the shared 32-bit system bus with 8-bit control. It arbitrates up to eight requesters (masters, and slaves returning read data, such as the SRAM controller) over per-port req/ack lines. It drives the granted port's data and control onto the single shared bus seen by all agents. It replaces fixed-priority selection with fair rotation, a mandatory turnaround cycle and an optional tenure watchdog.

## Interface
- BUS_WIDTH, 32, width of the shared data bus
- CTRL_WIDTH, 8, width of the shared control bus
- TIMEOUT, 256, max cycles a port may hold the grant (used only with the watchdog; legal 2..65535)
- clk  input  1  system clock; all logic on rising edge
- rst_L  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- req  input  8  request lines; bit i belongs to port i
- bus_in  input  8*BUS_WIDTH  port data, port i at [i*BUS_WIDTH +: BUS_WIDTH]
- ctrl_in  input  8*CTRL_WIDTH  port control, port i at [i*CTRL_WIDTH +: CTRL_WIDTH]
- ack  output  8  one-hot grant, registered
- bus_out  output  BUS_WIDTH  shared bus data
- ctrl_out  output  CTRL_WIDTH  shared bus control
- owner  output  3  index of current/last granted port
- busy  output  1  high while any ack bit is high
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant

## Operation
- States: IDLE, GRANTED, RELEASE.
- **Arbitration.** Runs in IDLE and RELEASE.
  - The search starts at (last_grant+1) mod 8 and wraps.
  - The first set req bit wins.
  - The FSM goes to GRANTED, sets owner = last_grant = winner and ack = one-hot(winner).
  - If no req bit is set: RELEASE goes to IDLE, and IDLE stays in IDLE.
- **GRANTED.** ack[owner] is held while req[owner]=1.
  - When req[owner]=0 is sampled, ack is cleared and the FSM goes to RELEASE.
  - Changes on other req bits are ignored while in GRANTED.
- **RELEASE.** Single turnaround cycle. ack=0 and busy=0.
- **Mux.** bus_out/ctrl_out are combinational from the registered owner.
  - In GRANTED they equal the owner's slice of bus_in/ctrl_in.
  - Otherwise they are all-zero.
  - Agents never drive the shared bus.
- **Reset values.** state=IDLE, ack=0, owner=0, last_grant=7 (so port 0 has first priority after reset), busy=0, timeout=0, watchdog counter=0, bus_out=0, ctrl_out=0.
- **Reset mid-grant.** rst_L=0 in any state returns all outputs to reset values on that edge. No RELEASE cycle is inserted.
- **Request behaviour.** A req pulse that rises and falls entirely while another port is granted is lost; requesters hold req until they see ack.

## Timing
- **Grant latency from IDLE.** req sampled high at edge n gives ack high after edge n (one registered stage). bus_out is valid in the same cycle ack is high.
- **Release.**
  - req[owner] sampled low at edge k clears ack after edge k.
  - RELEASE is the cycle after edge k.
  - The earliest next grant is after edge k+1.
  - Minimum gap between consecutive grants: exactly 1 cycle.
- **Back-to-back.** A single port that drops and re-raises req is re-granted only if no other port requests in RELEASE.
- **busy.** busy = |ack, registered together with ack.
- **Fairness.** With all 8 req bits held continuously, grants go in order 0,1,…,7,0. No port waits more than 7 tenures.

## Configuration
- Macro: BUS_RR_ARBITER_TIMEOUT_EN.
- **Defined.**
  - A 16-bit counter clears on entry to GRANTED and increments each GRANTED cycle.
  - When it reaches TIMEOUT-1 with req[owner] still high, ack is cleared, timeout pulses high for one cycle, and the FSM goes to RELEASE.
  - The revoked port is arbitrated normally afterwards; it has lowest priority due to rotation.
- **Undefined.**
  - The counter and the pulse logic are absent and timeout is tied 0.
  - A grant lasts until req drops.

## Test plan
- **Single request.** Reset, then req=8'h04 from cycle 3: ack=8'h04 one cycle later, owner=2, busy=1, bus_out=port 2 data (e.g. 32'hDEADBEEF). Then req=0: ack=0 next cycle, bus_out=0.
- **Reset priority.** After reset, req=8'h81 simultaneously: port 0 granted first. Port 0 drops req: one RELEASE cycle, then ack=8'h80.
- **Rotation.** req=8'hFF held, each owner drops and re-raises req after 3 cycles of ack: grant order 0..7,0, with exactly one zero-ack cycle between tenures.
- **Reset mid-grant.** Port 5 granted, rst_L=0 for one edge: ack=0, owner=0, bus_out=0 that cycle. With req=8'h20 still high, re-grant occurs one cycle after reset release.
- **Watchdog (macro defined, TIMEOUT=16).** Port 1 holds req for 40 cycles: ack drops after 16 granted cycles, timeout pulses once, then ack=8'h02 again. Repeat with req=8'h06: port 2 granted after the revocation.
- **Macro undefined.** Same stimulus: ack held all 40 cycles, timeout stays 0.
